// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer_if
//  Purpose  : Bundles the instruction stream, the ALU-facing bus, the result
//             stream and the carry/error status of the ALU op sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int BUS_WIDTH = 8
);
    // Instruction stream
    logic                 instr_valid;
    logic                 instr_ready;
    logic [9:0]           instr;
    logic [BUS_WIDTH-1:0] instr_imm;

    // ALU bus
    logic [BUS_WIDTH-1:0] alu_a;
    logic [BUS_WIDTH-1:0] alu_b;
    logic [3:0]           alu_opcode;
    logic                 alu_carry_in;
    logic [BUS_WIDTH-1:0] alu_y;
    logic                 alu_carry_out;
    logic                 alu_borrow;
    logic                 alu_zero;
    logic                 alu_parity;
    logic                 alu_invalid_op;

    // Result stream
    logic                 res_valid;
    logic                 res_ready;
    logic [BUS_WIDTH-1:0] res_data;
    logic [4:0]           res_flags;

    // Status
    logic                 carry_flag;
    logic                 err_sticky;
    logic                 err_clear;

    // Environment side: instruction source, ALU, result consumer
    modport master (
        output instr_valid, instr, instr_imm,
        output alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
        output res_ready, err_clear,
        input  instr_ready, alu_a, alu_b, alu_opcode, alu_carry_in,
        input  res_valid, res_data, res_flags, carry_flag, err_sticky
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instr, instr_imm,
        input  alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
        input  res_ready, err_clear,
        output instr_ready, alu_a, alu_b, alu_opcode, alu_carry_in,
        output res_valid, res_data, res_flags, carry_flag, err_sticky
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Issue/writeback stage in front of a combinational ALU. Reads
//             operands from a small register file, drives the ALU for one
//             cycle, writes the result back and emits a result/flag record.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_REGS  = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_LDI = 4'd0;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_instr_ready;
    logic                 w_res_valid;
    logic                 w_accept;

    logic [BUS_WIDTH-1:0] r_rf [NUM_REGS];
    logic [3:0]           r_opcode;
    logic [1:0]           r_rd;
    logic [BUS_WIDTH-1:0] r_imm;
    logic [BUS_WIDTH-1:0] r_a;
    logic [BUS_WIDTH-1:0] r_b;
    logic [BUS_WIDTH-1:0] r_res_data;
    logic [4:0]           r_res_flags;
    logic                 r_carry;
    logic                 r_err;
    logic                 w_exec_invalid;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; instr_ready depends on res_ready only in RESP
    always_comb begin
        w_state_nxt   = r_state;
        w_instr_ready = 1'b0;
        w_res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_instr_ready = 1'b1;
                if (bus.instr_valid) w_state_nxt = EXEC;
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_instr_ready = 1'b1;
                    w_state_nxt   = bus.instr_valid ? EXEC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept       = w_instr_ready & bus.instr_valid;
    assign w_exec_invalid = (r_state == EXEC) && (r_opcode != c_OP_LDI) && bus.alu_invalid_op;

    // Operand capture at accept, writeback and result capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_carry     <= 1'b0;
        end else begin
            if (w_accept) begin
                // Previous writeback has already landed, so dependent reads see the new value
                r_opcode <= bus.instr[9:6];
                r_rd     <= bus.instr[5:4];
                r_imm    <= bus.instr_imm;
                r_a      <= r_rf[bus.instr[3:2]];
                r_b      <= r_rf[bus.instr[1:0]];
            end
            if (r_state == EXEC) begin
                if (r_opcode == c_OP_LDI) begin
                    r_rf[r_rd]  <= r_imm;
                    r_res_data  <= r_imm;
                    r_res_flags <= {2'b00, (r_imm == '0), 2'b00};
                end else if (!bus.alu_invalid_op) begin
                    r_rf[r_rd]  <= bus.alu_y;
                    r_res_data  <= bus.alu_y;
                    r_res_flags <= {1'b0, bus.alu_parity, bus.alu_zero,
                                    bus.alu_borrow, bus.alu_carry_out};
                    r_carry     <= bus.alu_carry_out;
                end else begin
                    r_res_data  <= '0;
                    r_res_flags <= 5'b10000;
                end
            end
        end
    end

    // Sticky error: a set on the same edge as a clear takes priority
    always_ff @(posedge clk) begin
        if (!reset_n)            r_err <= 1'b0;
        else if (w_exec_invalid) r_err <= 1'b1;
        else if (bus.err_clear)  r_err <= 1'b0;
    end

    assign bus.instr_ready  = w_instr_ready;
    assign bus.res_valid    = w_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.res_flags    = r_res_flags;
    assign bus.alu_a        = r_a;
    assign bus.alu_b        = r_b;
    assign bus.alu_opcode   = r_opcode;
    assign bus.alu_carry_in = r_carry;
    assign bus.carry_flag   = r_carry;
    assign bus.err_sticky   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Self-checking bench for alu_op_sequencer with a behavioural ALU,
//             a register-file/carry reference model and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int BUS_WIDTH = 8;

    logic clk;
    logic reset_n;

    alu_op_sequencer_if #(.BUS_WIDTH(BUS_WIDTH)) bus ();

    alu_op_sequencer #(.BUS_WIDTH(BUS_WIDTH), .NUM_REGS(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {invalid, parity, zero, borrow, carry, y}
    function automatic logic [12:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        logic [8:0] t;
        logic       inv;
        logic       bo;
        logic [7:0] y;
        t   = '0;
        inv = 1'b0;
        bo  = 1'b0;
        case (op)
            4'd0: t = '0;
            4'd1: t = {1'b0, a} + {1'b0, b};
            4'd2: t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd3: begin t = {1'b0, a} - {1'b0, b}; bo = t[8]; t[8] = 1'b0; end
            4'd4: t = {1'b0, a & b};
            4'd5: t = {1'b0, a | b};
            4'd6: t = {1'b0, a ^ b};
            4'd7: t = {1'b0, ~a};
            4'd8: t = {a, 1'b0};
            4'd9: t = {a[0], 1'b0, a[7:1]};
            default: inv = 1'b1;
        endcase
        y = t[7:0];
        return {inv, ^y, (y == 8'd0), bo, t[8], y};
    endfunction

    logic [12:0] w_alu;
    assign w_alu              = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
    assign bus.alu_y          = w_alu[7:0];
    assign bus.alu_carry_out  = w_alu[8];
    assign bus.alu_borrow     = w_alu[9];
    assign bus.alu_zero       = w_alu[10];
    assign bus.alu_parity     = w_alu[11];
    assign bus.alu_invalid_op = w_alu[12];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model and scoreboard: entry = {carry_after, flags, data}
    logic [7:0]  m_rf [4];
    logic        m_carry;
    logic [13:0] sb_q [$];
    logic [7:0]  last_data;
    logic [4:0]  last_flags;
    int          last_waits;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
        m_carry = 1'b0;
    endtask

    // Result monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [13:0] e;
        if (reset_n && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("res_data",   bus.res_data,   e[7:0]);
                check("res_flags",  bus.res_flags,  e[12:8]);
                check("carry_flag", bus.carry_flag, e[13]);
                last_data  = bus.res_data;
                last_flags = bus.res_flags;
            end
        end
    end

    // Offer one instruction (call just after a rising edge); returns just after the accept edge
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        logic        rdy;
        int          waits;
        logic [12:0] r;
        logic [7:0]  ea, eb, d;
        logic [4:0]  f;
        logic        ecin;
        bus.instr_valid = 1'b1;
        bus.instr       = {op, rd, rs1, rs2};
        bus.instr_imm   = imm;
        rdy   = 1'b0;
        waits = 0;
        ea = 8'd0; eb = 8'd0; ecin = 1'b0;
        while (!rdy && waits < 40) begin
            @(negedge clk);
            rdy = bus.instr_ready;
            if (rdy) begin
                ea   = m_rf[rs1];
                eb   = m_rf[rs2];
                ecin = m_carry;
                r    = alu_ref(op, ea, eb, ecin);
                if (op == 4'd0) begin
                    d = imm;
                    f = {2'b00, (imm == 8'd0), 2'b00};
                    m_rf[rd] = imm;
                end else if (r[12]) begin
                    d = 8'd0;
                    f = 5'b10000;
                end else begin
                    d = r[7:0];
                    f = r[12:8];
                    m_rf[rd] = d;
                    m_carry  = f[0];
                end
                sb_q.push_back({m_carry, f, d});
            end
            @(posedge clk);
            if (!rdy) waits++;
        end
        #1;
        bus.instr_valid = 1'b0;
        last_waits = waits;
        check("accepted", rdy, 1);
        if (rdy) begin
            check("alu_a",        bus.alu_a,        ea);
            check("alu_b",        bus.alu_b,        eb);
            check("alu_opcode",   bus.alu_opcode,   op);
            check("alu_carry_in", bus.alu_carry_in, ecin);
        end
    endtask

    // Wait until every expected result has been seen
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.instr_imm   = '0;
        bus.res_ready   = 1'b1;
        bus.err_clear   = 1'b0;
        last_data       = '0;
        last_flags      = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_ready", bus.instr_ready, 1);
        check("rst_res_valid",   bus.res_valid,   0);
        check("rst_res_data",    bus.res_data,    0);
        check("rst_res_flags",   bus.res_flags,   0);
        check("rst_carry",       bus.carry_flag,  0);
        check("rst_err",         bus.err_sticky,  0);
        check("rst_alu_opcode",  bus.alu_opcode,  0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // LDI/ADD and dependent read-back
        issue(4'd0, 2'd1, 2'd0, 2'd0, 8'd9);
        issue(4'd0, 2'd2, 2'd0, 2'd0, 8'd33);
        issue(4'd1, 2'd3, 2'd1, 2'd2, 8'd0);
        drain();
        check("t1_add_data",  last_data,  42);
        check("t1_add_flags", last_flags, 5'b01000);
        check("t1_carry",     bus.carry_flag, 0);
        issue(4'd1, 2'd0, 2'd3, 2'd0, 8'd0);
        drain();
        check("t1_readback", last_data, 42);

        // Carry out, then add-with-carry consuming it
        issue(4'd0, 2'd0, 2'd0, 2'd0, 8'd200);
        issue(4'd0, 2'd1, 2'd0, 2'd0, 8'd100);
        issue(4'd1, 2'd2, 2'd0, 2'd1, 8'd0);
        drain();
        check("t2_add_data", last_data, 44);
        check("t2_carry",    bus.carry_flag, 1);
        issue(4'd2, 2'd3, 2'd1, 2'd1, 8'd0);
        drain();
        check("t2_adc_data", last_data, 201);
        check("t2_adc_carry", bus.carry_flag, 0);

        // Invalid opcode, sticky error, set-wins-over-clear
        issue(4'd12, 2'd1, 2'd1, 2'd1, 8'd0);
        drain();
        check("t3_inv_flags", last_flags, 5'b10000);
        check("t3_inv_data",  last_data,  0);
        check("t3_err_set",   bus.err_sticky, 1);
        issue(4'd13, 2'd2, 2'd0, 2'd0, 8'd0);
        bus.err_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clear = 1'b0;
        check("t3_set_wins", bus.err_sticky, 1);
        drain();
        bus.err_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clear = 1'b0;
        check("t3_err_cleared", bus.err_sticky, 0);
        issue(4'd1, 2'd2, 2'd1, 2'd0, 8'd0);
        drain();
        check("t3_rf1_kept", last_data, 44);

        // Backpressure
        bus.res_ready = 1'b0;
        issue(4'd0, 2'd2, 2'd0, 2'd0, 8'd77);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid",   bus.res_valid,   1);
            check("bp_res_data",    bus.res_data,    77);
            check("bp_res_flags",   bus.res_flags,   0);
            check("bp_instr_ready", bus.instr_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        issue(4'd0, 2'd3, 2'd0, 2'd0, 8'd5);
        check("bp_same_cycle_accept", last_waits, 0);
        @(negedge clk);
        check("bp_exec_no_valid", bus.res_valid, 0);
        @(negedge clk);
        check("bp_next_result", bus.res_valid, 1);
        drain();

        // Reset during EXEC
        issue(4'd0, 2'd0, 2'd0, 2'd0, 8'd200);
        issue(4'd0, 2'd1, 2'd0, 2'd0, 8'd100);
        issue(4'd1, 2'd2, 2'd0, 2'd1, 8'd0);
        drain();
        check("t5_carry_before", bus.carry_flag, 1);
        issue(4'd1, 2'd3, 2'd0, 2'd1, 8'd0);
        reset_n = 1'b0;
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        check("t5_res_valid",   bus.res_valid,   0);
        check("t5_instr_ready", bus.instr_ready, 1);
        check("t5_carry",       bus.carry_flag,  0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue(4'd1, 2'd0, 2'd1, 2'd2, 8'd0);
        issue(4'd1, 2'd1, 2'd3, 2'd3, 8'd0);
        drain();
        check("t5_rf_zero_data",  last_data,  0);
        check("t5_rf_zero_flags", last_flags, 5'b00100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
